// File: rtl/uart_pkg.sv
// Shared UART definitions for the weight link, used by both receiver and transmitter.
//   calc_div    : clocks per bit, rounded to nearest
//   bit_state_t : bit-level FSM states
//   FRAME_BYTES : bytes per weight frame
//   WEIGHT_W    : width of the signed weight
package uart_pkg;

  localparam int unsigned FRAME_BYTES = 4;
  localparam int unsigned WEIGHT_W    = 25;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } bit_state_t;

  // Round to nearest so 100 MHz / 9600 gives 10417 rather than 10416.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Single-byte UART receiver (8N1, LSB first).
//   clk_100MHz : system clock
//   rst        : asynchronous active-high reset
//   rx         : serial line, idle high, asynchronous
//   byte_data  : received byte, valid with byte_valid
//   byte_valid : 1-cycle strobe on a good stop bit
//   stop_err   : 1-cycle strobe on a low stop bit
//   busy       : start-bit detect until the stop-bit sample
//   idle       : bit FSM is waiting for a start bit
//   start_det  : start edge seen this cycle
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned DIV = 10417
) (
  input  logic       clk_100MHz,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       busy,
  output logic       idle,
  output logic       start_det
);

  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  logic [1:0]       sync_q;
  logic             rxs;
  bit_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shreg_q;

  assign rxs       = sync_q[1];
  assign idle      = (state_q == IDLE);
  assign start_det = idle && !rxs;

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      sync_q     <= 2'b11;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!rxs) begin
            cnt_q   <= CNT_HALF;
            state_q <= START;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (rxs) begin
              // Glitch shorter than half a bit: not a real start.
              state_q <= IDLE;
              busy    <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
              cnt_q     <= CNT_FULL;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shreg_q[bit_idx_q] <= rxs;
            cnt_q              <= CNT_FULL;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            busy <= 1'b0;
            if (rxs) begin
              byte_data  <= shreg_q;
              byte_valid <= 1'b1;
              state_q    <= IDLE;
            end else begin
              stop_err <= 1'b1;
              state_q  <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BREAK: begin
          // Hold here until the line recovers so a stuck-low line reports once.
          if (rxs) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_weight_rx.sv
// Weight-link receiver: reassembles 4-byte little-endian frames into a signed 25-bit weight.
//   clk_100MHz   : system clock
//   rst          : asynchronous active-high reset
//   rx           : serial line, idle high
//   weight_out   : signed weight from the last good frame (two's complement)
//   weight_valid : 1-cycle strobe, weight_out updated the same cycle
//   byte_out     : last good received byte
//   byte_valid   : 1-cycle strobe per good byte
//   frame_err    : 1-cycle strobe on bad stop bit or nonzero b3[7:1]
//   busy         : receiving a byte
module uart_weight_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned GAP_BITS = 12
) (
  input  logic                clk_100MHz,
  input  logic                rst,
  input  logic                rx,
  output logic [WEIGHT_W-1:0] weight_out,
  output logic                weight_valid,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  output logic                frame_err,
  output logic                busy
);

  localparam int unsigned DIV     = calc_div(CLK_HZ, BAUD);
  localparam int unsigned GAP_CYC = GAP_BITS * DIV;
  localparam int unsigned GAP_W   = $clog2(GAP_CYC + 1);
  localparam int unsigned IDX_W   = $clog2(FRAME_BYTES);
  localparam int unsigned STAGE_W = 8 * (FRAME_BYTES - 1);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BYTES - 1);

  logic [7:0]         rx_byte;
  logic               rx_byte_valid;
  logic               rx_stop_err;
  logic               rx_idle;
  logic               rx_start_det;
  logic [IDX_W-1:0]   idx_q;
  logic [STAGE_W-1:0] stage_q;
  logic [GAP_W-1:0]   gap_q;

  uart_rx_byte #(
    .DIV (DIV)
  ) u_rx_byte (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_valid (rx_byte_valid),
    .stop_err   (rx_stop_err),
    .busy       (busy),
    .idle       (rx_idle),
    .start_det  (rx_start_det)
  );

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      idx_q        <= '0;
      stage_q      <= '0;
      gap_q        <= '0;
      weight_out   <= '0;
      weight_valid <= 1'b0;
      byte_out     <= '0;
      byte_valid   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      weight_valid <= 1'b0;
      byte_valid   <= 1'b0;
      frame_err    <= 1'b0;

      // Inter-byte gap timer: only meaningful part-way through a frame.
      if (rx_start_det || idx_q == '0) begin
        gap_q <= '0;
      end else if (rx_idle) begin
        if (gap_q == GAP_LAST) begin
          gap_q <= '0;
          idx_q <= '0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end

      // Byte events win over the gap timer; the timer cannot expire mid-byte anyway.
      if (rx_stop_err) begin
        frame_err <= 1'b1;
        idx_q     <= '0;
      end else if (rx_byte_valid) begin
        byte_out   <= rx_byte;
        byte_valid <= 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_q <= '0;
          if (rx_byte[7:1] != 7'd0) begin
            frame_err <= 1'b1;
          end else begin
            weight_out   <= {rx_byte[0], stage_q};
            weight_valid <= 1'b1;
          end
        end else begin
          unique case (idx_q)
            2'd0:    stage_q[7:0]   <= rx_byte;
            2'd1:    stage_q[15:8]  <= rx_byte;
            default: stage_q[23:16] <= rx_byte;
          endcase
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_weight_rx.sv
`timescale 1ns/1ps
module tb_uart_weight_rx;

  // 2.5 MHz / 100 kBd -> 25 clocks per bit; the clock itself runs at 100 MHz in time units,
  // so one nominal bit is 250 ns.
  localparam int unsigned CLK_HZ   = 2_500_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned GAP_BITS = 12;
  localparam int          NOM_NS   = 250;

  logic        clk_100MHz = 1'b0;
  logic        rst        = 1'b1;
  logic        rx         = 1'b1;
  logic [24:0] weight_out;
  logic        weight_valid;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        frame_err;
  logic        busy;

  uart_weight_rx #(
    .CLK_HZ   (CLK_HZ),
    .BAUD     (BAUD),
    .GAP_BITS (GAP_BITS)
  ) dut (
    .clk_100MHz   (clk_100MHz),
    .rst          (rst),
    .rx           (rx),
    .weight_out   (weight_out),
    .weight_valid (weight_valid),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int checks = 0;
  int errors = 0;
  int bit_ns = NOM_NS;

  // Scoreboard queues and the frame-level reference model.
  logic [7:0]  exp_bytes[$];
  logic [24:0] exp_weights[$];
  int          exp_ferr = 0;
  int          frame[$];
  logic [24:0] model_weight = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // A byte that arrives with a good stop bit.
  task automatic model_good_byte(input logic [7:0] b);
    int w;
    exp_bytes.push_back(b);
    frame.push_back(int'(b));
    if (frame.size() == 4) begin
      if (frame[3] / 2 != 0) begin
        exp_ferr++;
      end else begin
        w = frame[0] + frame[1] * 256 + frame[2] * 65536 - ((frame[3] % 2) * 16777216);
        model_weight = 25'(w);
        exp_weights.push_back(model_weight);
      end
      frame.delete();
    end
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    #(n * bit_ns);
    if (n > GAP_BITS) frame.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) begin
      model_good_byte(b);
    end else begin
      exp_ferr++;
      frame.delete();
    end
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
  endtask

  task automatic drain(input string name);
    #(2 * bit_ns);
    checks++;
    if (exp_bytes.size() != 0 || exp_weights.size() != 0 || exp_ferr != 0) begin
      errors++;
      $display("FAIL %s drain: pending bytes=%0d weights=%0d frame_errs=%0d, required 0",
               name, exp_bytes.size(), exp_weights.size(), exp_ferr);
      exp_bytes.delete();
      exp_weights.delete();
      exp_ferr = 0;
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " weight_out"}, 32'(weight_out), 32'h0);
    check({name, " byte_out"}, 32'(byte_out), 32'h0);
    check({name, " strobes"}, {29'h0, weight_valid, byte_valid, frame_err}, 32'h0);
    check({name, " busy"}, 32'(busy), 32'h0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes.
  initial begin
    logic [7:0]  eb;
    logic [24:0] ew;
    forever begin
      @(negedge clk_100MHz);
      if (byte_valid) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          errors++;
          $display("FAIL byte_valid unexpected: byte_out=%h, no byte required", byte_out);
        end else begin
          eb = exp_bytes.pop_front();
          if (byte_out !== eb) begin
            errors++;
            $display("FAIL byte_out: got %h, required %h", byte_out, eb);
          end
        end
      end
      if (weight_valid) begin
        checks++;
        if (!byte_valid) begin
          errors++;
          $display("FAIL weight_valid without byte_valid: weight_out=%h", weight_out);
        end else if (exp_weights.size() == 0) begin
          errors++;
          $display("FAIL weight_valid unexpected: weight_out=%h, no weight required", weight_out);
        end else begin
          ew = exp_weights.pop_front();
          if (weight_out !== ew) begin
            errors++;
            $display("FAIL weight_out: got %h, required %h", weight_out, ew);
          end
        end
      end
      if (frame_err) begin
        checks++;
        if (exp_ferr == 0) begin
          errors++;
          $display("FAIL frame_err unexpected: got 1, required 0");
        end else begin
          exp_ferr--;
        end
      end
    end
  end

  initial begin
    int rates[3];
    int r;
    logic [7:0] b;

    rates[0] = NOM_NS;
    rates[1] = NOM_NS - 5;
    rates[2] = NOM_NS + 5;

    #23;
    check_reset_outputs("reset");
    rst = 1'b0;
    idle_bits(3);

    // 1: negative weight.
    send_byte(8'hFB, 1'b1); idle_bits(2);
    send_byte(8'hFF, 1'b1); idle_bits(2);
    send_byte(8'hFF, 1'b1); idle_bits(2);
    send_byte(8'h01, 1'b1);
    drain("t1");
    check("t1 weight_out", 32'(weight_out), 32'(model_weight));

    // 2: back-to-back bytes.
    send_frame(8'hDE, 8'hBC, 8'hAB, 8'h00);
    drain("t2");
    check("t2 weight_out", 32'(weight_out), 32'(model_weight));

    // 3: 0.3-bit glitch is a false start.
    rx = 1'b0;
    #(bit_ns * 3 / 10);
    rx = 1'b1;
    #(2 * bit_ns);
    check("t3 busy after glitch", 32'(busy), 32'h0);
    send_byte(8'h55, 1'b1);
    drain("t3");

    // 4: bad stop bit then line held low.
    send_byte(8'h00, 1'b0);
    #(20 * bit_ns);
    idle_bits(3);
    send_frame(8'h10, 8'h00, 8'h00, 8'h00);
    drain("t4");
    check("t4 weight_out", 32'(weight_out), 32'(model_weight));

    // 5: bad b3, then a partial frame abandoned by the gap timer.
    send_frame(8'h01, 8'h02, 8'h03, 8'h02);
    drain("t5a");
    check("t5 weight_out held", 32'(weight_out), 32'(model_weight));
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    idle_bits(13);
    send_frame(8'h07, 8'h00, 8'h00, 8'h00);
    drain("t5b");
    check("t5 weight_out", 32'(weight_out), 32'(model_weight));

    // 6: asynchronous reset inside byte 2, at nominal and +/-2% bit timing.
    for (int k = 0; k < 3; k++) begin
      bit_ns = rates[k];
      idle_bits(2);
      send_byte(8'($urandom), 1'b1);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 3; i++) begin
        rx = 1'($urandom);
        #(bit_ns);
      end
      #(bit_ns / 3);
      rst = 1'b1;
      #1;
      check_reset_outputs("t6 async reset");
      frame.delete();
      exp_bytes.delete();
      exp_weights.delete();
      exp_ferr     = 0;
      model_weight = '0;
      rx           = 1'b1;
      #37;
      rst = 1'b0;
      idle_bits(3);
      send_frame(8'hAA, 8'h00, 8'h00, 8'h00);
      drain("t6");
      check("t6 weight_out", 32'(weight_out), 32'(model_weight));
      // Leave a nonzero pattern so the next reset check is meaningful.
      send_frame(8'($urandom_range(1, 255)), 8'h00, 8'h00, 8'h01);
      drain("t6 refill");
    end

    // Random traffic against the frame model.
    bit_ns = NOM_NS;
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) idle_bits(r % 4);
      else idle_bits(13 + int'($urandom_range(0, 3)));
      if (frame.size() == 3 && $urandom_range(0, 3) != 0) b = 8'($urandom_range(0, 1));
      else b = 8'($urandom);
      if ($urandom_range(0, 11) == 0) begin
        send_byte(b, 1'b0);
        rx = 1'b0;
        #(int'($urandom_range(0, 3)) * bit_ns);
        idle_bits(2);
      end else begin
        send_byte(b, 1'b1);
      end
    end
    drain("random");
    check("random weight_out", 32'(weight_out), 32'(model_weight));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
